// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module  : branch_predictor_btb
// Brief   : Direct-mapped BTB with 2-bit saturating direction counters, EX-side
//           misprediction detection and branch/mispredict statistics.
// Revision: 1.0 - initial release
// ============================================================================
module branch_predictor_btb #(
    parameter int         DATA_WIDTH = 32,
    parameter int         IDX_BITS   = 4,
    parameter logic [1:0] CNT_INIT   = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] if_pc_i,
    output logic                  pred_hit_o,
    output logic                  pred_taken_o,
    output logic [DATA_WIDTH-1:0] pred_target_o,

    input  logic                  upd_valid_i,
    input  logic [DATA_WIDTH-1:0] upd_pc_i,
    input  logic                  upd_taken_i,
    input  logic [DATA_WIDTH-1:0] upd_target_i,
    input  logic                  upd_pred_taken_i,
    input  logic [DATA_WIDTH-1:0] upd_pred_target_i,

    output logic                  mispredict_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic [31:0]           stat_branches_o,
    output logic [31:0]           stat_mispredicts_o
);

    localparam int                    ENTRIES = 2 ** IDX_BITS;
    localparam int                    TAG_W   = DATA_WIDTH - IDX_BITS - 2;
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
    localparam logic [1:0]            CNT_MAX = 2'b11;
    localparam logic [1:0]            CNT_MIN = 2'b00;
    localparam logic [1:0]            CNT_NEW = 2'b10;

    // Flattened views of the per-entry state for the read muxes.
    logic [ENTRIES-1:0]         valid_vec;
    logic [ENTRIES-1:0][1:0]    cnt_vec;
    logic [TAG_W-1:0]           tag_vec    [ENTRIES];
    logic [DATA_WIDTH-1:0]      target_vec [ENTRIES];

    // ------------------------------------------------------------------
    // Predict path
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0]   if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic                  if_hit;
    logic                  if_taken;

    assign if_idx   = if_pc_i[IDX_BITS+1:2];
    assign if_tag   = if_pc_i[DATA_WIDTH-1:IDX_BITS+2];
    assign if_hit   = valid_vec[if_idx] && (tag_vec[if_idx] == if_tag);
    assign if_taken = if_hit && cnt_vec[if_idx][1];

    assign pred_hit_o    = if_hit;
    assign pred_taken_o  = if_taken;
    assign pred_target_o = if_taken ? target_vec[if_idx] : (if_pc_i + PC_STEP);

    // ------------------------------------------------------------------
    // Resolution path
    // ------------------------------------------------------------------
    logic                  dir_wrong;
    logic                  tgt_wrong;
    logic                  mispredict;

    assign dir_wrong  = (upd_taken_i != upd_pred_taken_i);
    assign tgt_wrong  = upd_taken_i && upd_pred_taken_i &&
                        (upd_target_i != upd_pred_target_i);
    assign mispredict = upd_valid_i && (dir_wrong || tgt_wrong);

    assign mispredict_o  = mispredict;
    assign redirect_pc_o = upd_taken_i ? upd_target_i : (upd_pc_i + PC_STEP);

    // ------------------------------------------------------------------
    // Training decode, shared by all entries
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0]   upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_hit;
    logic [1:0]            upd_cnt;
    logic [1:0]            upd_cnt_next;

    assign upd_idx = upd_pc_i[IDX_BITS+1:2];
    assign upd_tag = upd_pc_i[DATA_WIDTH-1:IDX_BITS+2];
    assign upd_hit = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);
    assign upd_cnt = cnt_vec[upd_idx];

    always_comb begin
        upd_cnt_next = upd_cnt;
        if (upd_taken_i) begin
            if (upd_cnt != CNT_MAX) begin
                upd_cnt_next = upd_cnt + 2'b01;
            end
        end else begin
            if (upd_cnt != CNT_MIN) begin
                upd_cnt_next = upd_cnt - 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------
    // Table entries
    // ------------------------------------------------------------------
    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        logic                  wr_sel;
        logic                  valid_q,  valid_d;
        logic [TAG_W-1:0]      tag_q,    tag_d;
        logic [DATA_WIDTH-1:0] target_q, target_d;
        logic [1:0]            cnt_q,    cnt_d;

        assign wr_sel = upd_valid_i && (upd_idx == IDX_BITS'(e));

        // Hits retrain in place; only taken misses allocate.
        always_comb begin
            valid_d  = valid_q;
            tag_d    = tag_q;
            target_d = target_q;
            cnt_d    = cnt_q;
            if (wr_sel) begin
                if (upd_hit) begin
                    cnt_d = upd_cnt_next;
                    if (upd_taken_i) begin
                        target_d = upd_target_i;
                    end
                end else if (upd_taken_i) begin
                    valid_d  = 1'b1;
                    tag_d    = upd_tag;
                    target_d = upd_target_i;
                    cnt_d    = CNT_NEW;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                cnt_q   <= CNT_INIT;
            end else begin
                valid_q  <= valid_d;
                tag_q    <= tag_d;
                target_q <= target_d;
                cnt_q    <= cnt_d;
            end
        end

        assign valid_vec[e]  = valid_q;
        assign cnt_vec[e]    = cnt_q;
        assign tag_vec[e]    = tag_q;
        assign target_vec[e] = target_q;
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [31:0] stat_branches_q,    stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    assign stat_branches_d    = stat_branches_q    + {31'd0, upd_valid_i};
    assign stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict};

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches_o    = stat_branches_q;
    assign stat_mispredicts_o = stat_mispredicts_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_predictor_btb
// Brief   : Self-checking bench for branch_predictor_btb against a table model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_predictor_btb;

    localparam int DW = 32;
    localparam int IB = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] if_pc;
    logic          pred_hit, pred_taken;
    logic [DW-1:0] pred_target;
    logic          upd_valid, upd_taken, upd_pred_taken;
    logic [DW-1:0] upd_pc, upd_target, upd_pred_target;
    logic          mispredict;
    logic [DW-1:0] redirect_pc;
    logic [31:0]   stat_branches, stat_mispredicts;

    int tests = 0;
    int fails = 0;

    // Reference model: one record per table slot, counter kept as 0..3.
    bit            m_valid  [N];
    logic [DW-1:0] m_tag    [N];
    logic [DW-1:0] m_target [N];
    int            m_cnt    [N];
    logic [31:0]   m_br, m_mp;

    always #5 clk = ~clk;

    branch_predictor_btb #(
        .DATA_WIDTH (DW),
        .IDX_BITS   (IB),
        .CNT_INIT   (2'b01)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .if_pc_i            (if_pc),
        .pred_hit_o         (pred_hit),
        .pred_taken_o       (pred_taken),
        .pred_target_o      (pred_target),
        .upd_valid_i        (upd_valid),
        .upd_pc_i           (upd_pc),
        .upd_taken_i        (upd_taken),
        .upd_target_i       (upd_target),
        .upd_pred_taken_i   (upd_pred_taken),
        .upd_pred_target_i  (upd_pred_target),
        .mispredict_o       (mispredict),
        .redirect_pc_o      (redirect_pc),
        .stat_branches_o    (stat_branches),
        .stat_mispredicts_o (stat_mispredicts)
    );

    function automatic int idx_of(input logic [DW-1:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [DW-1:0] tag_of(input logic [DW-1:0] pc);
        return pc / (4 * N);
    endfunction

    function automatic bit m_hit(input logic [DW-1:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_ptaken(input logic [DW-1:0] pc);
        return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [DW-1:0] m_ptarget(input logic [DW-1:0] pc);
        return m_ptaken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_misp();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target)));
    endfunction

    function automatic logic [DW-1:0] m_redirect();
        return upd_taken ? upd_target : upd_pc + 32'd4;
    endfunction

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        bit            r, v, t, mp;
        logic [DW-1:0] pc, tg;
        int            i;
        r  = rst;
        v  = upd_valid;
        t  = upd_taken;
        pc = upd_pc;
        tg = upd_target;
        mp = m_misp();
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 1'b0;
                m_cnt[k]   = 1;
            end
            m_br = 32'd0;
            m_mp = 32'd0;
        end else if (v) begin
            m_br = m_br + 32'd1;
            if (mp) m_mp = m_mp + 32'd1;
            i = idx_of(pc);
            if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
                if (t) begin
                    m_cnt[i]    = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                    m_target[i] = tg;
                end else begin
                    m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (t) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(pc);
                m_target[i] = tg;
                m_cnt[i]    = 2;
            end
        end
        #1;
    endtask

    task automatic set_upd(input bit v, input logic [DW-1:0] pc, input bit t,
                           input logic [DW-1:0] tg, input bit pt,
                           input logic [DW-1:0] ptg);
        upd_valid       = v;
        upd_pc          = pc;
        upd_taken       = t;
        upd_target      = tg;
        upd_pred_taken  = pt;
        upd_pred_target = ptg;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h8000_0010;
        tick();
        tests++;
        if (pred_hit !== 1'b0) begin
            fails++; $display("FAIL reset_hold_hit got=%b exp=0", pred_hit);
        end
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (pred_hit !== 1'b0) begin
            fails++; $display("FAIL reset_hit got=%b exp=0", pred_hit);
        end
        tests++;
        if (pred_taken !== 1'b0) begin
            fails++; $display("FAIL reset_taken got=%b exp=0", pred_taken);
        end
        tests++;
        if (pred_target !== 32'h8000_0014) begin
            fails++; $display("FAIL reset_target got=%h exp=80000014", pred_target);
        end
        tests++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            fails++; $display("FAIL reset_stats got=%0d/%0d exp=0/0",
                              stat_branches, stat_mispredicts);
        end
    endtask

    task automatic test_allocate();
        if_pc = 32'h8000_0010;
        set_upd(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0014);
        tests++;
        if (mispredict !== 1'b1) begin
            fails++; $display("FAIL alloc_misp got=%b exp=1", mispredict);
        end
        tests++;
        if (redirect_pc !== 32'h8000_0100) begin
            fails++; $display("FAIL alloc_redirect got=%h exp=80000100", redirect_pc);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        tests++;
        if ({pred_hit, pred_taken} !== 2'b11 || pred_target !== 32'h8000_0100) begin
            fails++; $display("FAIL alloc_predict got=%b%b/%h exp=11/80000100",
                              pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_saturation();
        bit outc  [9];
        bit exp_t [9];
        outc  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        if_pc = 32'h8000_0010;
        for (int s = 0; s < 9; s++) begin
            set_upd(1'b1, 32'h8000_0010, outc[s], 32'h8000_0100,
                    m_ptaken(32'h8000_0010), m_ptarget(32'h8000_0010));
            tests++;
            if (mispredict !== m_misp()) begin
                fails++; $display("FAIL sat_misp step=%0d got=%b exp=%b",
                                  s, mispredict, m_misp());
            end
            tick();
            upd_valid = 1'b0;
            #1;
            tests++;
            if (pred_taken !== exp_t[s] || pred_hit !== 1'b1) begin
                fails++; $display("FAIL sat_taken step=%0d got=%b hit=%b exp=%b",
                                  s, pred_taken, pred_hit, exp_t[s]);
            end
        end
    endtask

    task automatic test_wrong_target();
        if_pc = 32'h8000_0010;
        set_upd(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0100);
        tests++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h8000_0200) begin
            fails++; $display("FAIL wrong_tgt_misp got=%b/%h exp=1/80000200",
                              mispredict, redirect_pc);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        tests++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h8000_0200) begin
            fails++; $display("FAIL wrong_tgt_update got=%b/%h exp=1/80000200",
                              pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        if_pc = 32'h8000_0010;
        set_upd(1'b1, 32'h8000_0050, 1'b1, 32'h8000_0300, 1'b0, 32'h8000_0054);
        tests++;
        if (pred_hit !== 1'b1 || pred_target !== 32'h8000_0200) begin
            fails++; $display("FAIL alias_same_cycle got=%b/%h exp=1/80000200",
                              pred_hit, pred_target);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        tests++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h8000_0014) begin
            fails++; $display("FAIL alias_evicted got=%b/%h exp=0/80000014",
                              pred_hit, pred_target);
        end
        if_pc = 32'h8000_0050;
        #1;
        tests++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h8000_0300) begin
            fails++; $display("FAIL alias_new got=%b%b/%h exp=11/80000300",
                              pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_no_alloc_and_wrap();
        if_pc = 32'h8000_0020;
        set_upd(1'b1, 32'h8000_0020, 1'b0, 32'h8000_0400, 1'b0, 32'h8000_0024);
        tests++;
        if (mispredict !== 1'b0 || redirect_pc !== 32'h8000_0024) begin
            fails++; $display("FAIL nt_miss_misp got=%b/%h exp=0/80000024",
                              mispredict, redirect_pc);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        tests++;
        if (pred_hit !== 1'b0) begin
            fails++; $display("FAIL nt_no_alloc got=%b exp=0", pred_hit);
        end
        set_upd(1'b0, 32'h8000_0020, 1'b1, 32'h8000_0400, 1'b0, 32'h8000_0024);
        tests++;
        if (mispredict !== 1'b0) begin
            fails++; $display("FAIL invalid_no_misp got=%b exp=0", mispredict);
        end
        if_pc = 32'hFFFF_FFFC;
        set_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_5678);
        tests++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h0000_0000) begin
            fails++; $display("FAIL wrap_redirect got=%b/%h exp=1/00000000",
                              mispredict, redirect_pc);
        end
        tests++;
        if (pred_target !== 32'h0000_0000) begin
            fails++; $display("FAIL wrap_predict got=%h exp=00000000", pred_target);
        end
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic test_stats();
        logic [DW-1:0] pc;
        bit            mp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pc = 32'h9000_0000 + 32'(i * 4);
            mp = (i % 3 == 0) && (i < 9);
            set_upd(1'b1, pc, 1'b1, pc + 32'h100, ~mp, pc + 32'h100);
            tick();
        end
        upd_valid = 1'b0;
        #1;
        tests++;
        if (stat_branches !== 32'd10 || stat_mispredicts !== 32'd3) begin
            fails++; $display("FAIL stats got=%0d/%0d exp=10/3",
                              stat_branches, stat_mispredicts);
        end
    endtask

    task automatic test_reset_with_update();
        rst = 1'b1;
        set_upd(1'b1, 32'h9000_0000, 1'b1, 32'h9000_0500, 1'b0, 32'h9000_0004);
        tick();
        rst = 1'b0;
        upd_valid = 1'b0;
        #1;
        tests++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            fails++; $display("FAIL rst_upd_stats got=%0d/%0d exp=0/0",
                              stat_branches, stat_mispredicts);
        end
        for (int i = 0; i < N; i++) begin
            if_pc = 32'h9000_0000 + 32'(i * 4);
            #1;
            tests++;
            if (pred_hit !== 1'b0 || pred_target !== if_pc + 32'd4) begin
                fails++; $display("FAIL rst_upd_empty idx=%0d got=%b/%h exp=0/%h",
                                  i, pred_hit, pred_target, if_pc + 32'd4);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] pc;
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 59) == 0);
            if_pc = 32'h8000_0000 + 32'($urandom_range(0, 2) * 64) +
                    32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            pc    = 32'h8000_0000 + 32'($urandom_range(0, 2) * 64) +
                    32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 1) == 0) pc = if_pc;
            set_upd($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1,
                    32'h8000_1000 + 32'($urandom_range(0, 3) * 4),
                    m_ptaken(pc),
                    ($urandom_range(0, 3) == 0) ? 32'h8000_1000 : m_ptarget(pc));
            tests++;
            if (pred_hit !== m_hit(if_pc) || pred_taken !== m_ptaken(if_pc) ||
                pred_target !== m_ptarget(if_pc)) begin
                fails++; $display("FAIL rnd_predict n=%0d pc=%h got=%b%b/%h exp=%b%b/%h",
                                  n, if_pc, pred_hit, pred_taken, pred_target,
                                  m_hit(if_pc), m_ptaken(if_pc), m_ptarget(if_pc));
            end
            tests++;
            if (mispredict !== m_misp() ||
                (upd_valid && redirect_pc !== m_redirect())) begin
                fails++; $display("FAIL rnd_resolve n=%0d got=%b/%h exp=%b/%h",
                                  n, mispredict, redirect_pc, m_misp(), m_redirect());
            end
            tick();
            tests++;
            if (stat_branches !== m_br || stat_mispredicts !== m_mp) begin
                fails++; $display("FAIL rnd_stats n=%0d got=%0d/%0d exp=%0d/%0d",
                                  n, stat_branches, stat_mispredicts, m_br, m_mp);
            end
        end
        rst = 1'b0;
        upd_valid = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        if_pc           = 32'h0;
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
        m_br            = 32'd0;
        m_mp            = 32'd0;
        @(negedge clk);
        test_reset();
        test_allocate();
        test_saturation();
        test_wrong_target();
        test_alias();
        test_no_alloc_and_wrap();
        test_stats();
        test_reset_with_update();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Fetch-side branch predictor and BTB, the producer of the predictions that EX-stage branch resolution checks.
- IF stage presents the fetch PC and receives a combinational prediction: taken flag and target.
- EX stage returns each resolved branch: actual outcome, target, and the prediction it carried. The block trains its tables, flags mispredictions with the redirect PC, and keeps performance counters.

Parameters:
- DATA_WIDTH, 32, PC/target width.
- IDX_BITS, 4, log2 of table entries (ENTRIES = 2^IDX_BITS, direct-mapped).
- CNT_INIT, 2'b01, reset value of every 2-bit saturating counter (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  DATA_WIDTH  fetch PC to predict.
- pred_hit  out  1  valid entry with matching tag for if_pc.
- pred_taken  out  1  predicted taken.
- pred_target  out  DATA_WIDTH  predicted next PC.
- upd_valid  in  1  EX presents a resolved conditional branch this cycle.
- upd_pc  in  DATA_WIDTH  PC of the resolved branch.
- upd_taken  in  1  actual outcome from the branch comparator.
- upd_target  in  DATA_WIDTH  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipe with the branch.
- upd_pred_target  in  DATA_WIDTH  predicted target carried down the pipe.
- mispredict  out  1  resolved branch disagrees with its prediction.
- redirect_pc  out  DATA_WIDTH  correct next PC when mispredict=1.
- stat_branches  out  32  resolved-branch count.
- stat_mispredicts  out  32  mispredict count.

Behaviour:
- Entry fields: valid, tag = pc[DATA_WIDTH-1:IDX_BITS+2], target, cnt[1:0].
- Index = pc[IDX_BITS+1:2]; pc[1:0] ignored.
- Reset (rst=1 at an edge):
  - all valid=0, all cnt=CNT_INIT, stat counters=0; targets don't-care.
  - Reset dominates an upd_valid in the same cycle: no training, no count.
- Predict path is combinational from current table state, zero latency:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & cnt[1].
  - pred_target = pred_taken ? entry target : if_pc+4.
  - Outputs during/after reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Mispredict path is combinational in the upd_valid cycle:
  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - upd_valid=0 forces mispredict=0.
- Training at the edge when upd_valid=1 and rst=0:
  - Hit (valid & tag match): cnt saturating +1 if taken, -1 if not (3 stays 3, 0 stays 0). If taken, target <= upd_target.
  - Miss and taken: allocate/overwrite the entry. valid=1, tag, target=upd_target, cnt=2'b10.
  - Miss and not taken: no change (no allocation on not-taken).
- Stats:
  - stat_branches increments on every upd_valid.
  - stat_mispredicts increments when mispredict=1.
  - Both wrap modulo 2^32.
- Simultaneous predict and update to the same index: the prediction uses pre-update contents. No write-to-read bypass; the new state is visible from the next cycle.
- Aliasing: a different tag at the same index is a miss. A taken update evicts the old entry.
- PC+4 arithmetic wraps modulo 2^DATA_WIDTH (0xFFFF_FFFC+4 = 0).
- No stall input: the IF stage holds if_pc when stalled; EX asserts upd_valid exactly once per branch.

Test Plan:
- Post-reset lookup: if_pc=0x8000_0010 -> pred_hit=0, pred_taken=0, pred_target=0x8000_0014.
- Allocate then predict:
  - Update upd_pc=0x8000_0010, taken=1, target=0x8000_0100, pred_taken=0 -> mispredict=1, redirect_pc=0x8000_0100.
  - Next cycle, if_pc=0x8000_0010 -> hit=1, taken=1, target=0x8000_0100.
- Saturation:
  - Two more taken updates -> cnt=3.
  - One not-taken -> still predicts taken.
  - Three more not-taken -> cnt=0 and pred_taken=0; a fourth keeps cnt=0.
- Wrong target: upd_taken=1, pred_taken=1, upd_target=0x8000_0200, pred_target=0x8000_0100 -> mispredict=1, redirect=0x8000_0200. Entry target becomes 0x8000_0200.
- Alias eviction and same-cycle rule:
  - With 0x8000_0010 trained, a taken update at 0x8000_0050 (same index, new tag) evicts it; 0x8000_0010 then misses.
  - A lookup in the update cycle shows the old entry.
- Stats and reset: 10 updates with 3 mispredicts -> stat_branches=10, stat_mispredicts=3. rst=1 together with upd_valid -> counters=0 and the table is empty next cycle.
